btn_led_avalon_slave: RTL and testbench
=======================================

BTN_LED_AVALON_SLAVE -- requirements
Module: btn_led_avalon_slave

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of pushbutton inputs.
REQ-002 SHALL have parameter NUM_LED, default 8: number of LED outputs.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable-input clocks required to accept a button change (1 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1: single system clock, all logic rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, 2: Avalon-MM word address.
REQ-007 SHALL have port read, input, 1: Avalon-MM read strobe.
REQ-008 SHALL have port write, input, 1: Avalon-MM write strobe.
REQ-009 SHALL have port writedata, input, 32: Avalon-MM write data.
REQ-010 SHALL have port readdata, output, 32: Avalon-MM read data.
REQ-011 SHALL have port irq, output, 1: level interrupt to the CPU.
REQ-012 SHALL have port pb_n, input, NUM_BTN: raw asynchronous pushbuttons; 0 = pressed.
REQ-013 SHALL have port led, output, NUM_LED: LED drive; 1 = LED on.

Function
REQ-014 SHALL pass each pb_n bit through a 2-flop synchronizer preset to 1.
REQ-015 SHALL give each button its own debounce counter.
- Synchronized input equal to debounced state: counter clears to 0.
- Input differs: counter increments.
- Counter reaches DEBOUNCE_CYCLES-1 while input still differs: debounced state takes the input and the counter clears on that clock.
REQ-016 SHALL size each counter as clog2(DEBOUNCE_CYCLES) bits and never wrap.
REQ-017 SHALL raise a one-clock press pulse when a debounced bit goes 1->0; release (0->1) raises no pulse.
REQ-018 SHALL decode the register map (all reads zero-extend to 32 bits):
- 0 DATA, RO: ~debounced state, 1 = pressed.
- 1 LED, RW: led_reg[NUM_LED-1:0].
- 2 IRQMASK, RW: mask[NUM_BTN-1:0].
- 3 EDGECAP, RW1C: edge[NUM_BTN-1:0].
REQ-019 SHALL return readdata on the clock after read is sampled (read latency 1, no waitrequest); readdata is 0 on any clock after a clock with read low.
REQ-020 SHALL apply a write to its register on the clock after write is sampled.
REQ-021 SHALL ignore writes to DATA and writedata bits above each register's width.
REQ-022 SHALL set an edge bit on a press pulse and clear it when 1 is written to that bit at EDGECAP.
REQ-023 SHALL keep the edge bit set when a press pulse and a clearing write hit the same bit on the same clock (set wins).
REQ-024 SHALL drive irq = |(edge & mask), registered, one clock after edge or mask changes.
REQ-025 SHALL drive led = led_reg directly.
REQ-026 SHALL treat read and write asserted together as a write only; readdata stays 0.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously force:
- synchronizers and debounced state to all 1s;
- counters, led_reg, mask, edge, readdata and irq to 0.
REQ-028 SHALL abandon any partial debounce count when reset asserts mid-operation, with no press pulse on reset release.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 SHALL be verified for basic press: pb_n[0] held 0 for 10 clocks -> DATA reads 0x1, EDGECAP reads 0x1; irq stays 0 while mask=0.
REQ-030 SHALL be verified for bounce rejection: pb_n[1] toggled every 2 clocks for 20 clocks, then held 1 -> DATA 0x0, EDGECAP 0x0.
REQ-031 SHALL be verified for interrupt: IRQMASK=0x4, press pb_n[2] -> irq=1; write 0x4 to EDGECAP -> irq=0 two clocks after the write strobe.
REQ-032 SHALL be verified for set-wins: clear write to EDGECAP bit 3 on the press-pulse clock -> EDGECAP reads 0x8.
REQ-033 SHALL be verified for LED: write 0xFFFFFFA5 to address 1 -> led=0xA5 next clock, readback 0x000000A5; write to address 0 leaves DATA unchanged.
REQ-034 SHALL be verified for reset mid-operation: reset_n pulsed low at count 2 while pb_n[0]=0 -> all outputs 0; press then debounces afresh, taking 2 synchronizer clocks plus 4 debounce clocks after release.

Source files
------------

// File: rtl/btn_led_avalon_slave.sv
// rtl/btn_led_avalon_slave.sv - pushbutton/LED register slave with debounce, edge capture and IRQ
module btn_led_avalon_slave #(
  parameter int NUM_BTN         = 4,
  parameter int NUM_LED         = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  input  logic [NUM_BTN-1:0] pb_n,
  output logic [NUM_LED-1:0] led
);

  localparam int CNT_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_LED     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync_q;
  logic [NUM_BTN-1:0] db_q;
  logic [NUM_BTN-1:0] db_prev;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [NUM_BTN-1:0] press;

  logic [NUM_LED-1:0] led_reg;
  logic [NUM_BTN-1:0] mask_q;
  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_BTN-1:0] edge_nxt;
  logic [31:0]        rd_mux;

  logic wr_led;
  logic wr_mask;
  logic wr_edge;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      sync_meta <= pb_n;
      sync_q    <= sync_meta;
    end
  end

  // The counter only advances while the synchronized input disagrees with the
  // accepted state, so it saturates at CNT_LAST and is cleared on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q    <= '1;
      db_prev <= '1;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_prev <= db_q;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_prev & ~db_q;

  assign wr_led  = write && (address == ADDR_LED);
  assign wr_mask = write && (address == ADDR_IRQMASK);
  assign wr_edge = write && (address == ADDR_EDGECAP);

  // Press is OR'd in after the clear so a simultaneous press keeps the bit.
  always_comb begin
    edge_nxt = edge_q;
    if (wr_edge) begin
      edge_nxt = edge_nxt & ~writedata[NUM_BTN-1:0];
    end
    edge_nxt = edge_nxt | press;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[NUM_BTN-1:0] = ~db_q;
      ADDR_LED:     rd_mux[NUM_LED-1:0] = led_reg;
      ADDR_IRQMASK: rd_mux[NUM_BTN-1:0] = mask_q;
      default:      rd_mux[NUM_BTN-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_reg  <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_led) begin
        led_reg <= writedata[NUM_LED-1:0];
      end
      if (wr_mask) begin
        mask_q <= writedata[NUM_BTN-1:0];
      end
      edge_q   <= edge_nxt;
      readdata <= (read && !write) ? rd_mux : '0;
      irq      <= |(edge_q & mask_q);
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_btn_led_avalon_slave.sv
// tb/tb_btn_led_avalon_slave.sv - directed checks for btn_led_avalon_slave
module tb_btn_led_avalon_slave;

  localparam int NUM_BTN = 4;
  localparam int NUM_LED = 8;
  localparam int DEB     = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [1:0]         address = '0;
  logic               read = 1'b0;
  logic               write = 1'b0;
  logic [31:0]        writedata = '0;
  logic [31:0]        readdata;
  logic               irq;
  logic [NUM_BTN-1:0] pb_n = '1;
  logic [NUM_LED-1:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  btn_led_avalon_slave #(
    .NUM_BTN(NUM_BTN),
    .NUM_LED(NUM_LED),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .pb_n(pb_n),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    d       = readdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 2'd1, 32'hFFFF_FFA5, 32'h0000_00A5};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0000_00A5};
    vecs[2]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_00A5};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0000};
    vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFF3, 32'h0000_00A5};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0003};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0000};
    vecs[7]  = '{1'b1, 2'd1, 32'h0000_015A, 32'h0000_005A};
    vecs[8]  = '{1'b0, 2'd1, 32'h0,         32'h0000_005A};
    vecs[9]  = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_005A};
    vecs[10] = '{1'b0, 2'd2, 32'h0,         32'h0000_0000};

    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
        check($sformatf("vec%0d_led", i), 32'(led), vecs[i].exp);
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
      end
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
    end

    @(negedge clk);
    check("rd_idle_zero", readdata, 32'h0);

    address   = 2'd1;
    writedata = 32'h0000_0033;
    read      = 1'b1;
    write     = 1'b1;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    check("rdwr_readdata", readdata, 32'h0);
    check("rdwr_led", 32'(led), 32'h33);

    // basic press with mask clear
    pb_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("press_irq_masked", 32'(irq), 32'h0);
    bus_read(2'd0, rd);
    check("press_data", rd, 32'h1);
    bus_read(2'd3, rd);
    check("press_edge", rd, 32'h1);
    pb_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(2'd0, rd);
    check("release_data", rd, 32'h0);
    bus_read(2'd3, rd);
    check("release_edge_kept", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    check("edge_w1c", rd, 32'h0);

    // bounce on button 1 never settles long enough
    for (int k = 0; k < 10; k++) begin
      pb_n[1] = ~pb_n[1];
      repeat (2) @(negedge clk);
    end
    pb_n[1] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(2'd0, rd);
    check("bounce_data", rd, 32'h0);
    bus_read(2'd3, rd);
    check("bounce_edge", rd, 32'h0);

    // interrupt on button 2
    bus_write(2'd2, 32'h4);
    pb_n[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    bus_read(2'd3, rd);
    check("irq_edge", rd, 32'h4);
    address   = 2'd3;
    writedata = 32'h4;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("irq_hold_1clk", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clear_2clk", 32'(irq), 32'h0);
    pb_n[2] = 1'b1;
    repeat (10) @(negedge clk);

    // set wins: clear write lands on the press-pulse clock of button 3
    bus_write(2'd2, 32'h8);
    pb_n[3] = 1'b0;
    repeat (6) @(negedge clk);
    address   = 2'd3;
    writedata = 32'h8;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    bus_read(2'd3, rd);
    check("set_wins_edge", rd, 32'h8);
    pb_n[3] = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'h1);

    // reset mid-count on button 0
    pb_n[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd3, rd);
    check("postrst_no_pulse", rd, 32'h0);
    repeat (4) @(negedge clk);
    bus_read(2'd0, rd);
    check("postrst_data_early", rd, 32'h0);
    bus_read(2'd0, rd);
    check("postrst_data_settled", rd, 32'h1);
    bus_read(2'd3, rd);
    check("postrst_edge", rd, 32'h1);
    check("postrst_irq_masked", 32'(irq), 32'h0);
    check("postrst_led", 32'(led), 32'h0);
    pb_n[0] = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
